uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped 8N1 UART transmitter on the data-memory bus of the single-cycle processor. It consumes the processor's store traffic: a word store to the data register pushes a byte into a small FIFO. A serializer drains the FIFO onto the TX pin. A status register lets software poll for full, empty, busy and overflow.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥ 2.
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of two and ≥ 2.
- BASE_ADDR, 32'h0000_1000: byte address of the data register. The status register is at BASE_ADDR+4.

Ports:
- CLK  in  1  processor clock; all state on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- WE  in  1  processor MemWrite.
- ADDR  in  32  processor ALU result (data address).
- WDATA  in  32  processor store data.
- RDATA  out  32  read data for the load mux; combinational.
- TX  out  1  serial line; idles high.

## Operation
- Write to BASE_ADDR with WE=1:
  - If the FIFO is not full, push WDATA[7:0].
  - If it is full, drop the write and set the sticky OVF flag.
- Write to BASE_ADDR+4 with WDATA[3]=1 clears OVF. All other write bits are ignored.
- Writes to any other address are ignored.
- Read mux:
  - ADDR==BASE_ADDR+4: RDATA = {28'b0, OVF, BUSY, EMPTY, FULL}, with FULL in bit 0.
  - ADDR==BASE_ADDR: RDATA = 0.
  - Any other address: RDATA = 0.
  - The mux does not depend on WE.
- BUSY = FSM state is not IDLE.
- FSM states IDLE, START, DATA, STOP:
  - IDLE, FIFO non-empty: pop the head into the shift register, clear the bit counter, load the bit timer, go to START.
  - START: TX=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: TX=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After 8 bits go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- The bit timer counts CLKS_PER_BIT-1 down to 0. The state advances on the cycle the timer reads 0.
- The bit counter is 3 bits and wraps naturally after bit 7.
- TX is registered (glitch-free).

## Timing
- Reset values: TX=1, state=IDLE, FIFO empty, OVF=0, shift register=0, timers=0. RDATA follows ADDR combinationally.
- A write is sampled at edge k and is visible in the FIFO and in STATUS after edge k.
- From IDLE, the pop happens at edge k+1 and TX goes low after edge k+1. Write-to-start-bit latency is therefore 1 cycle after the write edge.
- A frame lasts exactly 10·CLKS_PER_BIT cycles. Back-to-back frames have no gap.
- Simultaneous push and pop when FULL: the pop frees a slot and the push is accepted; OVF is not set.
- Push when EMPTY: no bypass; the byte always passes through the FIFO.
- Simultaneous push and pop when count is 1: count stays 1.
- Simultaneous overflowing write and OVF-clear: impossible, because they use different addresses in the same cycle.
- Reset asserted mid-frame: TX goes to 1 immediately (asynchronous). FIFO contents and the partial frame are discarded. After release, the block is silent until the next write.

## Structure
- Package uart_pkg holds:
  - enum tx_state_t {IDLE, START, DATA, STOP};
  - register offsets DATA_OFS=0 and STAT_OFS=4;
  - status bit positions FULL_BIT=0, EMPTY_BIT=1, BUSY_BIT=2, OVF_BIT=3.
- One sub-module, fifo_sync:
  - parameters WIDTH and DEPTH;
  - ports push, pop, din, dout, full, empty;
  - pointers one bit wider than the address, for full/empty detection;
  - async active-low reset.
- The top holds the address decode, OVF and the TX FSM.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Write 0x000000A5 to 0x1000 → TX low from the next edge. Per-bit values are 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). BUSY=1 throughout, then TX=1 and STATUS=0x2.
- Write 0x55 then 0x0F on consecutive cycles → two frames with no gap, 80 cycles total. The second start bit immediately follows the first stop bit.
- Write 6 bytes in 6 consecutive cycles:
  - the first is popped at once, so FIFO holds 4 and the 6th overflows;
  - STATUS reads 0x9|0x4 = 0xD;
  - exactly 5 frames are transmitted;
  - writing 0x8 to 0x1004 clears OVF.
- When FULL, pop coincides with a write → byte accepted, OVF stays 0, and the byte appears in order.
- Assert RST_N low during bit 3 of a frame → TX=1 asynchronously, STATUS=0x2 after release, no further frames.
- Read 0x1008 and write 0x1008 → RDATA=0, no FIFO or flag change.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register map constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [31:0] DATA_OFS = 32'd0;
  localparam logic [31:0] STAT_OFS = 32'd4;

  localparam int FULL_BIT  = 0;
  localparam int EMPTY_BIT = 1;
  localparam int BUSY_BIT  = 2;
  localparam int OVF_BIT   = 3;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push is accepted while full when a pop frees a slot.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// 8N1 UART transmitter on the processor data bus: data register feeds a FIFO, status register reports flags.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        TX
);

  localparam int            TW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_RELOAD = TW'(CLKS_PER_BIT - 1);

  tx_state_t     r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic [TW-1:0] r_timer;
  logic          r_tx;
  logic          r_ovf;

  logic          w_sel_data;
  logic          w_sel_stat;
  logic          w_wr_data;
  logic          w_wr_stat;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_dout;
  logic          w_busy;
  logic          w_unused;

  assign w_sel_data = (ADDR == BASE_ADDR + DATA_OFS);
  assign w_sel_stat = (ADDR == BASE_ADDR + STAT_OFS);
  assign w_wr_data  = WE && w_sel_data;
  assign w_wr_stat  = WE && w_sel_stat;
  assign w_busy     = (r_state != IDLE);
  assign w_unused   = ^WDATA[31:8];

  // A frame is loaded from IDLE, or straight out of the last stop-bit cycle so frames abut.
  assign w_pop = !w_empty &&
                 ((r_state == IDLE) || (r_state == STOP && r_timer == '0));

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (w_wr_data),
    .pop   (w_pop),
    .din   (WDATA[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ovf <= 1'b0;
    end else if (w_wr_data && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (w_wr_stat && WDATA[OVF_BIT]) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_timer   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift   <= w_dout;
            r_bit_cnt <= '0;
            r_timer   <= T_RELOAD;
            r_tx      <= 1'b0;
            r_state   <= START;
          end
        end
        START: begin
          if (r_timer == '0) begin
            r_timer <= T_RELOAD;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        DATA: begin
          if (r_timer == '0) begin
            r_timer   <= T_RELOAD;
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_tx <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        STOP: begin
          if (r_timer == '0) begin
            if (w_pop) begin
              r_shift   <= w_dout;
              r_bit_cnt <= '0;
              r_timer   <= T_RELOAD;
              r_tx      <= 1'b0;
              r_state   <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign TX = r_tx;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    RDATA = '0;
    if (w_sel_stat) begin
      RDATA[FULL_BIT]  = w_full;
      RDATA[EMPTY_BIT] = w_empty;
      RDATA[BUSY_BIT]  = w_busy;
      RDATA[OVF_BIT]   = r_ovf;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: register vectors, cycle-exact TX streams and a frame scoreboard.
module tb_uart_tx_mmio;
  import uart_pkg::*;

  localparam int          CPB   = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] STAT  = 32'h0000_1004;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic        WE    = 1'b0;
  logic [31:0] ADDR  = STAT;
  logic [31:0] WDATA = '0;
  logic [31:0] RDATA;
  logic        TX;

  int         n_checks  = 0;
  int         n_pass    = 0;
  int         rx_frames = 0;
  logic       rst_seen  = 1'b0;
  logic [7:0] sb_q [$];

  always #5 CLK = ~CLK;

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .BASE_ADDR    (BASE)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .WE    (WE),
    .ADDR  (ADDR),
    .WDATA (WDATA),
    .RDATA (RDATA),
    .TX    (TX)
  );

  always @(negedge RST_N) rst_seen = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic exp_tx(input logic [7:0] b [8], input int n, input int c);
    int bp;
    logic [7:0] d;
    if (c < 0 || c >= n * FRAME) return 1'b1;
    bp = (c % FRAME) / CPB;
    d  = b[c / FRAME];
    if (bp == 0) return 1'b0;
    if (bp == 9) return 1'b1;
    return d[bp-1];
  endfunction

  // Checks TX and BUSY every cycle from stream cycle c0 (current time) to the end of n frames.
  task automatic watch_stream(input logic [7:0] b [8], input int n, input int c0);
    for (int c = c0; c < n * FRAME; c++) begin
      if (c != c0) @(negedge CLK);
      check($sformatf("tx_c%0d", c), TX, exp_tx(b, n, c));
      check($sformatf("busy_c%0d", c), RDATA[BUSY_BIT], c >= 0);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    WE = 1'b1; ADDR = addr; WDATA = data;
    @(negedge CLK);
    WE = 1'b0; ADDR = STAT;
    #1;
  endtask

  task automatic burst(input logic [7:0] b [8], input int n, input int n_accept);
    for (int i = 0; i < n; i++) begin
      WE = 1'b1; ADDR = BASE; WDATA = {24'h5A_C3_96, b[i]};
      if (i < n_accept) sb_q.push_back(b[i]);
      @(negedge CLK);
    end
    WE = 1'b0; ADDR = STAT;
    #1;
  endtask

  // Serial receiver: samples each bit in its second cycle and scores completed frames.
  initial begin : rx
    logic [7:0] data;
    logic       s0;
    logic       s9;
    logic [7:0] exp_b;
    forever begin
      @(negedge CLK);
      if (RST_N && TX === 1'b0) begin
        rst_seen = 1'b0;
        @(negedge CLK);
        s0 = TX;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          data[i] = TX;
        end
        repeat (CPB) @(negedge CLK);
        s9 = TX;
        if (!rst_seen) begin
          rx_frames++;
          check("rx_start_bit", s0, 1'b0);
          check("rx_stop_bit", s9, 1'b1);
          check("rx_frame_expected", sb_q.size() > 0, 1'b1);
          if (sb_q.size() > 0) begin
            exp_b = sb_q.pop_front();
            check("rx_byte", data, exp_b);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected summary by 100000 ns");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_stat;
  } vec_t;

  initial begin : main
    vec_t       vecs [9];
    logic       a5_bits [10];
    logic [7:0] b [8];
    int         frames0;
    int         lows;

    vecs[0] = '{1'b0, 32'h0000_1004, 32'h0,         32'h2, 32'h2};
    vecs[1] = '{1'b0, 32'h0000_1000, 32'h0,         32'h0, 32'h2};
    vecs[2] = '{1'b0, 32'h0000_1008, 32'h0,         32'h0, 32'h2};
    vecs[3] = '{1'b1, 32'h0000_1008, 32'hFFFF_FFFF, 32'h0, 32'h2};
    vecs[4] = '{1'b1, 32'h0000_1004, 32'h0000_0008, 32'h2, 32'h2};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0, 32'h2};
    vecs[6] = '{1'b1, 32'h0000_1004, 32'h0,         32'h2, 32'h2};
    vecs[7] = '{1'b0, 32'h0000_1005, 32'h0,         32'h0, 32'h2};
    vecs[8] = '{1'b1, 32'h0000_0000, 32'h0000_00FF, 32'h0, 32'h2};
    a5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset_tx", TX, 1'b1);
    check("reset_status", RDATA, 32'h2);
    RST_N = 1'b1;
    @(negedge CLK);

    // Register-access vectors: read mux, WE independence, ignored addresses
    for (int i = 0; i < 9; i++) begin
      WE = vecs[i].we; ADDR = vecs[i].addr; WDATA = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_rdata", i), RDATA, vecs[i].exp_rd);
      @(negedge CLK);
      WE = 1'b0; ADDR = STAT;
      #1;
      check($sformatf("vec%0d_status", i), RDATA, vecs[i].exp_stat);
      check($sformatf("vec%0d_tx_idle", i), TX, 1'b1);
    end

    // Single frame 0xA5 against the explicit bit table
    sb_q.push_back(8'hA5);
    bus_write(BASE, 32'h0000_00A5);
    check("a5_status_after_write", RDATA, 32'h0);
    check("a5_tx_before_pop", TX, 1'b1);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge CLK);
      check($sformatf("a5_tx_c%0d", c), TX, a5_bits[c / CPB]);
      check($sformatf("a5_status_c%0d", c), RDATA, 32'h6);
    end
    @(negedge CLK);
    check("a5_tx_after", TX, 1'b1);
    check("a5_status_after", RDATA, 32'h2);

    // Two back-to-back frames with no gap
    b = '{8'h55, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    burst(b, 2, 2);
    watch_stream(b, 2, 0);
    @(negedge CLK);
    check("b2b_tx_after", TX, 1'b1);
    check("b2b_status_after", RDATA, 32'h2);

    // Six writes: the sixth overflows, five frames go out, OVF cleared only by bit 3
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77, 8'h00, 8'h00};
    burst(b, 6, 5);
    check("ovf_status_full", RDATA, 32'hD);
    watch_stream(b, 5, 4);
    @(negedge CLK);
    check("ovf_status_sticky", RDATA, 32'hA);
    check("ovf_tx_after", TX, 1'b1);
    bus_write(STAT, 32'h0000_0007);
    check("ovf_not_cleared_by_other_bits", RDATA, 32'hA);
    bus_write(STAT, 32'h0000_0008);
    check("ovf_cleared", RDATA, 32'h2);

    // Write while full on the very edge the FSM pops: accepted, no OVF
    b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h00, 8'h00};
    burst(b, 5, 5);
    check("popfull_status_before", RDATA, 32'h5);
    repeat (36) @(negedge CLK);
    check("popfull_tx_last_stop", TX, 1'b1);
    sb_q.push_back(8'hF6);
    bus_write(BASE, 32'h0000_00F6);
    check("popfull_status_after", RDATA, 32'h5);
    watch_stream(b, 6, 40);
    @(negedge CLK);
    check("popfull_status_end", RDATA, 32'h2);
    check("popfull_tx_end", TX, 1'b1);

    // Asynchronous reset during data bit 3
    sb_q.push_back(8'h00);
    bus_write(BASE, 32'h0000_0000);
    repeat (18) @(negedge CLK);
    check("rst_tx_in_bit3", TX, 1'b0);
    #2;
    RST_N = 1'b0;
    sb_q.delete();
    #1;
    check("rst_tx_async", TX, 1'b1);
    check("rst_status_during", RDATA, 32'h2);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("rst_status_after", RDATA, 32'h2);
    frames0 = rx_frames;
    lows = 0;
    repeat (100) begin
      @(negedge CLK);
      if (TX !== 1'b1) lows++;
    end
    check("rst_silent_tx", lows, 0);
    check("rst_no_frames", rx_frames, frames0);
    check("rst_status_final", RDATA, 32'h2);

    repeat (10) @(negedge CLK);
    check("scoreboard_drained", sb_q.size(), 0);
    check("total_frames", rx_frames, 14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
